// File: rtl/wb_mux_to.sv
// Single-master, N-slave Wishbone classic decoder/mux with registered decode, unmapped-address
// error and per-access response watchdog. Optional error capture under WB_MUX_ERR_CAPTURE_EN.
module wb_mux_to #(
  parameter int                         NUM_SLAVES = 3,
  parameter int                         AW         = 32,
  parameter int                         DW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0]   MATCH_ADDR = '0,
  parameter logic [NUM_SLAVES*AW-1:0]   MATCH_MASK = '0,
  parameter int                         TIMEOUT    = 255
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [AW-1:0]                wbm_adr_i,
  input  logic [DW-1:0]                wbm_dat_i,
  input  logic [DW/8-1:0]              wbm_sel_i,
  input  logic                         wbm_we_i,
  input  logic                         wbm_cyc_i,
  input  logic                         wbm_stb_i,
  input  logic [2:0]                   wbm_cti_i,
  input  logic [1:0]                   wbm_bte_i,
  output logic [DW-1:0]                wbm_dat_o,
  output logic                         wbm_ack_o,
  output logic                         wbm_err_o,
  output logic                         wbm_rty_o,
  output logic [NUM_SLAVES*AW-1:0]     wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]     wbs_dat_o,
  output logic [NUM_SLAVES*DW/8-1:0]   wbs_sel_o,
  output logic [NUM_SLAVES*3-1:0]      wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]      wbs_bte_o,
  output logic [NUM_SLAVES-1:0]        wbs_we_o,
  output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]        wbs_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]     wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]        wbs_err_i,
  input  logic [NUM_SLAVES-1:0]        wbs_rty_i
`ifdef WB_MUX_ERR_CAPTURE_EN
  ,
  output logic [AW-1:0]                err_adr_o,
  output logic [1:0]                   err_code_o
`endif
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DECERR, TOERR} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]   hit_vec;
  logic                    hit;
  logic [DW-1:0]           s_dat;
  logic                    s_ack, s_err, s_rty;

  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}} & sel_q;

  // Scan from the top so the lowest matching index is the last one written and wins.
  always_comb begin
    hit_vec = '0;
    hit     = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((wbm_adr_i & MATCH_MASK[i*AW +: AW]) == MATCH_ADDR[i*AW +: AW]) begin
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

  always_comb begin
    s_dat = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        s_dat = s_dat | wbs_dat_i[i*DW +: DW];
        s_ack = s_ack | wbs_ack_i[i];
        s_err = s_err | wbs_err_i[i];
        s_rty = s_rty | wbs_rty_i[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    wbm_dat_o = '0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_rty_o = 1'b0;
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (hit) begin
            sel_d   = hit_vec;
            cnt_d   = '0;
            state_d = ACTIVE;
          end else begin
            state_d = DECERR;
          end
        end
      end
      ACTIVE: begin
        wbs_cyc_o = sel_q & {NUM_SLAVES{wbm_cyc_i}};
        wbs_stb_o = sel_q & {NUM_SLAVES{wbm_stb_i}};
        wbm_dat_o = s_dat;
        wbm_ack_o = s_ack;
        wbm_err_o = s_err;
        wbm_rty_o = s_rty;
        // A response on the last counted cycle beats the watchdog.
        if (s_ack || s_err || s_rty || !wbm_cyc_i) begin
          sel_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          sel_d   = '0;
          state_d = TOERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DECERR, TOERR: begin
        wbm_err_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WB_MUX_ERR_CAPTURE_EN
  logic [AW-1:0] err_adr_q;
  logic [1:0]    err_code_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      err_adr_q  <= '0;
      err_code_q <= '0;
    end else if (state_d == DECERR) begin
      err_adr_q  <= wbm_adr_i;
      err_code_q <= 2'b01;
    end else if (state_d == TOERR) begin
      err_adr_q  <= wbm_adr_i;
      err_code_q <= 2'b10;
    end
  end

  assign err_adr_o  = err_adr_q;
  assign err_code_o = err_code_q;
`endif

endmodule

// File: tb/tb_wb_mux_to.sv
// Scoreboard bench for wb_mux_to: main instance (16-byte windows, short watchdog) plus an
// overlapping-window instance for decode priority.
module tb_wb_mux_to;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] dat;
    int          lat;
    logic [N-1:0] stb_mask;
    int          stb_cycles;
    logic        cyc_hi;
    int          req;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_dat = '0;
  logic [3:0]    m_sel = 4'hF;
  logic          m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
  logic [2:0]    m_cti = '0;
  logic [1:0]    m_bte = '0;
  logic [DW-1:0] m_rdat;
  logic          m_ack, m_err, m_rty;

  logic [N*AW-1:0] s_adr;
  logic [N*DW-1:0] s_wdat, s_rdat;
  logic [N*4-1:0]  s_sel;
  logic [N*3-1:0]  s_cti;
  logic [N*2-1:0]  s_bte;
  logic [N-1:0]    s_we, s_cyc, s_stb, s_ack, s_err, s_rty;

  logic          b_cyc = 1'b0, b_stb = 1'b0;
  logic [DW-1:0] b_rdat;
  logic          b_ack, b_err, b_rty;
  logic [N*AW-1:0] bs_adr;
  logic [N*DW-1:0] bs_wdat;
  logic [N*4-1:0]  bs_sel;
  logic [N*3-1:0]  bs_cti;
  logic [N*2-1:0]  bs_bte;
  logic [N-1:0]    bs_we, bs_cyc, bs_stb;
  logic [N*DW-1:0] bs_rdat = {32'hB2, 32'hB1, 32'hB0};

`ifdef WB_MUX_ERR_CAPTURE_EN
  logic [AW-1:0] cap_adr, cap_adr_b;
  logic [1:0]    cap_code, cap_code_b;
`endif

  wb_mux_to #(
    .NUM_SLAVES(N), .AW(AW), .DW(DW),
    .MATCH_ADDR({32'h20, 32'h10, 32'h00}),
    .MATCH_MASK({32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0}),
    .TIMEOUT(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(m_rdat), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat), .wbs_sel_o(s_sel), .wbs_cti_o(s_cti),
    .wbs_bte_o(s_bte), .wbs_we_o(s_we), .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb),
    .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty)
`ifdef WB_MUX_ERR_CAPTURE_EN
    , .err_adr_o(cap_adr), .err_code_o(cap_code)
`endif
  );

  wb_mux_to #(
    .NUM_SLAVES(N), .AW(AW), .DW(DW),
    .MATCH_ADDR({32'h20, 32'h10, 32'h00}),
    .MATCH_MASK({32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFF00}),
    .TIMEOUT(8)
  ) dut_ovl (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(b_cyc), .wbm_stb_i(b_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(b_rdat), .wbm_ack_o(b_ack), .wbm_err_o(b_err), .wbm_rty_o(b_rty),
    .wbs_adr_o(bs_adr), .wbs_dat_o(bs_wdat), .wbs_sel_o(bs_sel), .wbs_cti_o(bs_cti),
    .wbs_bte_o(bs_bte), .wbs_we_o(bs_we), .wbs_cyc_o(bs_cyc), .wbs_stb_o(bs_stb),
    .wbs_dat_i(bs_rdat), .wbs_ack_i(bs_stb), .wbs_err_i(3'b000), .wbs_rty_i(3'b000)
`ifdef WB_MUX_ERR_CAPTURE_EN
    , .err_adr_o(cap_adr_b), .err_code_o(cap_code_b)
`endif
  );

  // Slave models: respond with {rty,err,ack}=s_mode after s_wait stb cycles; drive data only then.
  logic [2:0]  s_mode [N] = '{default: '0};
  int          s_wait [N] = '{default: 0};
  logic [31:0] s_val  [N] = '{default: '0};
  int          s_cnt  [N] = '{default: 0};
  logic [31:0] wr_seen[N] = '{default: '0};
  logic        spur0 = 1'b0;

  always_comb begin
    s_ack  = '0;
    s_err  = '0;
    s_rty  = '0;
    s_rdat = '0;
    for (int i = 0; i < N; i++) begin
      if (s_stb[i] && s_cnt[i] == s_wait[i] && s_mode[i] != 3'b000) begin
        s_ack[i] = s_mode[i][0];
        s_err[i] = s_mode[i][1];
        s_rty[i] = s_mode[i][2];
        s_rdat[i*DW +: DW] = s_val[i];
      end
    end
    if (spur0) s_ack[0] = 1'b1;
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (s_stb[i] && !(s_ack[i] || s_err[i] || s_rty[i])) s_cnt[i] <= s_cnt[i] + 1;
      else s_cnt[i] <= 0;
      if (s_stb[i] && s_ack[i] && s_we[i]) wr_seen[i] <= s_wdat[i*DW +: DW];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  exp_t q[$];
  exp_t qb[$];
  int resp_cnt = 0;
  int b_resp_cnt = 0;
  logic [N-1:0] stb_seen = '0;
  int stb_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stb_seen = '0;
      stb_cyc  = 0;
    end else begin
      stb_seen = stb_seen | s_stb;
      if (s_stb != '0) stb_cyc++;
      if (m_ack || m_err || m_rty) begin
        resp_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got ack/err/rty=%b%b%b with nothing expected (cycle %0d)",
                   m_ack, m_err, m_rty, cyc_n);
        end else begin
          e = q.pop_front();
          chk("resp_kind", 32'({m_rty, m_err, m_ack}), 32'(e.kind));
          chk("resp_dat", m_rdat, e.dat);
          chk("resp_latency", 32'(cyc_n - e.req), 32'(e.lat));
          chk("stb_mask", 32'(stb_seen), 32'(e.stb_mask));
          chk("stb_cycles", 32'(stb_cyc), 32'(e.stb_cycles));
          chk("cyc_at_resp", 32'(|s_cyc), 32'(e.cyc_hi));
        end
        stb_seen = '0;
        stb_cyc  = 0;
      end else begin
        chk("idle_dat", m_rdat, 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (b_ack || b_err || b_rty)) begin
      b_resp_cnt++;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ovl_unexpected: got ack/err/rty=%b%b%b (cycle %0d)", b_ack, b_err, b_rty, cyc_n);
      end else begin
        e = qb.pop_front();
        chk("ovl_kind", 32'({b_rty, b_err, b_ack}), 32'(e.kind));
        chk("ovl_dat", b_rdat, e.dat);
        chk("ovl_stb", 32'(bs_stb), 32'(e.stb_mask));
      end
    end
  end

  task automatic acc(input logic [31:0] a, input logic we, input logic [31:0] d,
                     input logic [2:0] kind, input logic [31:0] edat, input int lat,
                     input logic [N-1:0] mask, input int scyc, input logic cyc_hi);
    exp_t e;
    int start;
    e.kind = kind; e.dat = edat; e.lat = lat; e.stb_mask = mask;
    e.stb_cycles = scyc; e.cyc_hi = cyc_hi; e.req = cyc_n;
    q.push_back(e);
    start = resp_cnt;
    m_adr = a; m_we = we; m_dat = d; m_cyc = 1'b1; m_stb = 1'b1;
    for (int n = 0; n < 40 && resp_cnt == start; n++) begin
      @(posedge clk); #1;
    end
    if (resp_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: no response for adr 0x%08h within 40 cycles", a);
      q.delete();
    end
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t eb;
    int start;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_err_rty", 32'({m_ack, m_err, m_rty}), 32'h0);
    chk("rst_dat", m_rdat, 32'h0);
    chk("rst_wbs_cyc_stb", 32'({s_cyc, s_stb}), 32'h0);
`ifdef WB_MUX_ERR_CAPTURE_EN
    chk("rst_cap", 32'({cap_adr[7:0], cap_code}), 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write to slave1, immediate ack.
    s_mode[1] = 3'b001; s_wait[1] = 0; s_val[1] = 32'h0;
    acc(32'h14, 1'b1, 32'hA5A5A5A5, 3'b001, 32'h0, 1, 3'b010, 1, 1'b1);
    chk("wr_data_s1", wr_seen[1], 32'hA5A5A5A5);
    chk("wr_untouched_s0_s2", wr_seen[0] | wr_seen[2], 32'h0);

    // Read slave2 with 3 wait states while slave0 acks spuriously.
    spur0 = 1'b1;
    s_mode[2] = 3'b001; s_wait[2] = 3; s_val[2] = 32'h12345678;
    acc(32'h24, 1'b0, 32'h0, 3'b001, 32'h12345678, 4, 3'b100, 4, 1'b1);
    spur0 = 1'b0;

    // Unmapped address.
    acc(32'h40, 1'b0, 32'h0, 3'b010, 32'h0, 1, 3'b000, 0, 1'b0);
`ifdef WB_MUX_ERR_CAPTURE_EN
    chk("cap_dec_adr", cap_adr, 32'h40);
    chk("cap_dec_code", 32'(cap_code), 32'h1);
`endif

    // Silent slave0 -> watchdog error.
    s_mode[0] = 3'b000;
    acc(32'h04, 1'b0, 32'h0, 3'b010, 32'h0, 9, 3'b001, 8, 1'b0);
`ifdef WB_MUX_ERR_CAPTURE_EN
    chk("cap_to_adr", cap_adr, 32'h04);
    chk("cap_to_code", 32'(cap_code), 32'h2);
`endif

    // Ack on the last counted cycle wins over the watchdog.
    s_mode[0] = 3'b001; s_wait[0] = 7; s_val[0] = 32'h5A5A0000;
    acc(32'h08, 1'b0, 32'h0, 3'b001, 32'h5A5A0000, 8, 3'b001, 8, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Simultaneous ack and err are both forwarded.
    s_mode[2] = 3'b011; s_wait[2] = 1; s_val[2] = 32'h0BADF00D;
    acc(32'h2C, 1'b0, 32'h0, 3'b011, 32'h0BADF00D, 2, 3'b100, 2, 1'b1);

    // Retry.
    s_mode[1] = 3'b100; s_wait[1] = 0; s_val[1] = 32'h0;
    acc(32'h1C, 1'b0, 32'h0, 3'b100, 32'h0, 1, 3'b010, 1, 1'b1);

    // Reset during a wait state with the master still requesting.
    s_mode[2] = 3'b000;
    m_adr = 32'h24; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_wbs_cyc_stb", 32'({s_cyc, s_stb}), 32'h0);
    chk("midrst_ack_err", 32'({m_ack, m_err, m_rty}), 32'h0);
    m_cyc = 1'b0; m_stb = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    s_mode[1] = 3'b001; s_wait[1] = 0; s_val[1] = 32'hCAFE0001;
    acc(32'h10, 1'b0, 32'h0, 3'b001, 32'hCAFE0001, 1, 3'b010, 1, 1'b1);

    // Overlapping windows: 0x18 hits slave0 and slave1; slave0 must win.
    eb.kind = 3'b001; eb.dat = 32'hB0; eb.lat = 1; eb.stb_mask = 3'b001;
    eb.stb_cycles = 1; eb.cyc_hi = 1'b1; eb.req = cyc_n;
    qb.push_back(eb);
    start = b_resp_cnt;
    m_adr = 32'h18; b_cyc = 1'b1; b_stb = 1'b1;
    for (int n = 0; n < 40 && b_resp_cnt == start; n++) begin
      @(posedge clk); #1;
    end
    if (b_resp_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL ovl_timeout: no response from overlap instance within 40 cycles");
    end
    b_cyc = 1'b0; b_stb = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size() + qb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_mux_to.md
Name: wb_mux_to

Overview:
Parametrised single-master, N-slave Wishbone classic decoder/mux with a registered address decode, unmapped-address error generation and a per-access response watchdog. It sits between the IO master port and the peripheral slaves (SPI, UART and later additions). It supersedes the fixed three-slave combinational mux: the slave count, widths and address map are parameters, and a hung or missing slave can no longer stall the master.

Parameters:
NUM_SLAVES, 3, number of slave ports (1..16)
AW, 32, address width
DW, 32, data width (multiple of 8)
MATCH_ADDR, {NUM_SLAVES*AW{1'b0}}, packed base addresses; slave i at bits [i*AW +: AW]
MATCH_MASK, {NUM_SLAVES*AW{1'b0}}, packed masks; slave i hit when (adr & mask_i) == addr_i
TIMEOUT, 255, cycles in ACTIVE without ack/err/rty before a bus error (1..65535)

Ports:
wb_clk_i  in  1  clock, all logic rising-edge
wb_rst_i  in  1  synchronous, active-low reset
wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  AW/DW/DW/8/1/1/1/3/2  master request
wbm_dat_o  out  DW  read data to master
wbm_ack_o / wbm_err_o / wbm_rty_o  out  1 each  master response
wbs_adr_o/dat_o/sel_o/cti_o/bte_o  out  NUM_SLAVES*(AW/DW/DW/8/3/2)  broadcast request, slave i at [i*W +: W]
wbs_we_o/cyc_o/stb_o  out  NUM_SLAVES  per-slave control
wbs_dat_i  in  NUM_SLAVES*DW  slave read data
wbs_ack_i/err_i/rty_i  in  NUM_SLAVES  slave responses

Behaviour:
- Reset (wb_rst_i==0 at a clock edge): state IDLE, sel_q=0, timeout counter=0; all wbm_ack/err/rty_o=0, wbm_dat_o=0, all wbs_cyc/stb_o=0.
- adr/dat/sel/cti/bte broadcast unregistered to every slave; wbs_we_o[i] = wbm_we_i & sel_q[i].
- Decode: lowest-index matching slave wins on overlapping windows.
- FSM states IDLE, ACTIVE, DECERR, TOERR.
- IDLE: wbm_cyc_i&wbm_stb_i and a hit -> latch one-hot sel_q, counter=0, go ACTIVE. No hit -> DECERR. Master outputs all 0.
- ACTIVE: wbs_cyc_o[i] = sel_q[i]&wbm_cyc_i; wbs_stb_o[i] = sel_q[i]&wbm_stb_i. wbm_dat_o/ack/err/rty combinationally forwarded from the selected slave. On any of ack/err/rty -> IDLE next cycle. wbm_cyc_i low -> IDLE, no response. Otherwise counter++; counter==TIMEOUT-1 with no response -> TOERR.
- DECERR / TOERR: wbm_err_o=1 for exactly one cycle, all wbs_cyc/stb_o=0, wbm_dat_o=0, then IDLE.
- Latency: request seen in IDLE at cycle T -> slave stb at T+1 -> earliest master ack at T+1 (combinational slave ack). One IDLE cycle separates consecutive accesses.
- Simultaneous slave ack and err: both forwarded; the master resolves. Response on the same cycle the counter reaches its limit: the response wins and no TOERR is generated.
- Responses from unselected slaves are ignored.
- Reset mid-access: FSM returns to IDLE on the edge; no response is delivered.

Optional Feature:
Macro WB_MUX_ERR_CAPTURE_EN.
- Defined: adds outputs err_adr_o [AW] and err_code_o [2] (01=decode, 10=timeout), both registered. They load wbm_adr_i on entry to DECERR/TOERR, hold until the next error, and reset to 0.
- Undefined: ports absent, no capture logic.

Test Plan:
- NUM_SLAVES=3, map 0x00/0x10/0x20 (mask 0xFFFFFFF0). Write 0xA5A5A5A5 to 0x14; slave1 acks at the first stb cycle -> wbs_stb_o=3'b010 for 1 cycle, wbm_ack_o=1, slaves 0/2 untouched.
- Read 0x24; slave2 returns 0x12345678 with ack after 3 wait cycles -> wbm_dat_o=0x12345678 exactly in the ack cycle, 0 otherwise.
- Access 0x40 (unmapped) -> no wbs_stb_o, wbm_err_o=1 one cycle after the request. With WB_MUX_ERR_CAPTURE_EN: err_adr_o=0x40, err_code_o=01.
- TIMEOUT=8, slave0 never acks -> wbm_err_o pulses 9 cycles after the request, wbs_cyc_o[0] drops the same cycle. With the macro: err_code_o=10.
- Overlapping windows (slave0 mask 0xFFFFFF00, slave1 0x10/0xFFFFFFF0); access 0x18 -> slave0 selected.
- Assert wb_rst_i=0 during an ACTIVE wait state -> next cycle all wbs_cyc/stb_o=0 and no wbm ack/err; the following access decodes normally.
